// File: rtl/spectrum_frame_packer_pkg.sv
// Shared definitions for the spectrum frame packer.
//   state_t          : packer FSM states (idle, capture, one state per sent byte)
//   HDR0_BYTE/HDR1_BYTE : default frame header bytes
//   DEFAULT_N_PIXELS : default samples per line
//   addr_width()     : line buffer address width for a given line length
package spectrum_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CAPTURE = 3'd1,
        ST_HDR0    = 3'd2,
        ST_HDR1    = 3'd3,
        ST_FCNT    = 3'd4,
        ST_DATA_LO = 3'd5,
        ST_DATA_HI = 3'd6,
        ST_CSUM    = 3'd7
    } state_t;

    localparam logic [7:0] HDR0_BYTE        = 8'hAA;
    localparam logic [7:0] HDR1_BYTE        = 8'h55;
    localparam int         DEFAULT_N_PIXELS = 3648;

    function automatic int addr_width(input int n_pixels);
        return (n_pixels < 2) ? 1 : $clog2(n_pixels);
    endfunction

endpackage

// File: rtl/spectrum_frame_packer_if.sv
// Valid/ready byte stream between the frame packer and the UART TX stage.
//   tx_data       : byte offered to the UART
//   tx_data_valid : tx_data is valid (held until accepted)
//   tx_data_ready : UART accepts the byte this cycle
// master = byte producer (packer), slave = byte consumer (UART TX).
interface spectrum_frame_packer_if;
    logic [7:0] tx_data;
    logic       tx_data_valid;
    logic       tx_data_ready;

    modport master (output tx_data, output tx_data_valid, input tx_data_ready);
    modport slave  (input tx_data, input tx_data_valid, output tx_data_ready);
endinterface

// File: rtl/spectrum_frame_packer_line_ram.sv
// Line buffer: simple dual-port RAM, DEPTH x WIDTH, one synchronous write
// port and one registered read port (rdata shows mem[raddr] one cycle after
// raddr is presented). No reset on storage so it maps onto block RAM.
//   clk   : clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : registered read data
module spectrum_line_ram
    import spectrum_pkg::*;
#(
    parameter int DEPTH = DEFAULT_N_PIXELS,
    parameter int WIDTH = 12,
    parameter int AW    = addr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read port
    always_ff @(posedge clk) begin
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/spectrum_frame_packer.sv
// Spectrum frame packer: captures one line of N_PIXELS samples into a line
// buffer, then sends it as AA 55 FCNT {LO,HI}xN CSUM over a valid/ready byte
// stream. sof pulses arriving while a frame is being sent are counted as
// dropped lines and otherwise ignored.
// Ports:
//   clk_50m        : clock, rising edge
//   rst            : synchronous active-high reset
//   sample_data    : ADC sample
//   sample_valid   : sample_data valid
//   sample_sof     : this sample is pixel 0 of a line
//   tx             : byte stream to UART TX (master modport)
//   busy           : FSM not idle
//   frame_done     : pulse in the cycle the checksum byte is accepted
//   dropped_frames : saturating count of ignored sof events
// Build option: SPECTRUM_TEST_PATTERN_EN stores the pixel index (ramp)
// instead of sample_data.
module spectrum_frame_packer
    import spectrum_pkg::*;
#(
    parameter int         N_PIXELS = DEFAULT_N_PIXELS,
    parameter int         SAMPLE_W = 12,
    parameter logic [7:0] HDR0     = HDR0_BYTE,
    parameter logic [7:0] HDR1     = HDR1_BYTE
) (
    input  logic                    clk_50m,
    input  logic                    rst,
    input  logic [SAMPLE_W-1:0]     sample_data,
    input  logic                    sample_valid,
    input  logic                    sample_sof,
    spectrum_frame_packer_if.master tx,
    output logic                    busy,
    output logic                    frame_done,
    output logic [7:0]              dropped_frames
);

    localparam int          AW        = addr_width(N_PIXELS);
    localparam logic [AW-1:0] LAST_ADDR = AW'(N_PIXELS - 1);

    function automatic logic [7:0] lo_byte(input logic [SAMPLE_W-1:0] s);
        return s[7:0];
    endfunction

    function automatic logic [7:0] hi_byte(input logic [SAMPLE_W-1:0] s);
        logic [15:0] w;
        w = 16'(s);
        return w[15:8];
    endfunction

    state_t              state_r, state_s;
    logic [AW-1:0]       wr_addr_r, wr_addr_s;
    logic [AW-1:0]       rd_idx_r, rd_idx_s;
    logic [AW-1:0]       next_idx_s;
    logic [AW-1:0]       ram_raddr_s;
    logic [AW-1:0]       ram_waddr_s;
    logic                ram_we_s;
    logic [SAMPLE_W-1:0] ram_wdata_s;
    logic [SAMPLE_W-1:0] ram_rdata_s;
    logic [7:0]          tx_data_r, tx_data_s;
    logic                tx_valid_r, tx_valid_s;
    logic [7:0]          csum_r, csum_s;
    logic [7:0]          fcnt_r, fcnt_s;
    logic [7:0]          drop_r, drop_s;
    logic                busy_r, busy_s;
    logic                frame_done_s;
    logic                xfer_s;
    logic                sof_s;
    logic                sending_s;

    assign xfer_s     = tx_valid_r && tx.tx_data_ready;
    assign sof_s      = sample_valid && sample_sof;
    assign sending_s  = (state_r != ST_IDLE) && (state_r != ST_CAPTURE);
    // Clamp at the last pixel so the read address never leaves the buffer.
    assign next_idx_s = (rd_idx_r == LAST_ADDR) ? rd_idx_r : rd_idx_r + AW'(1);

`ifdef SPECTRUM_TEST_PATTERN_EN
    assign ram_wdata_s = SAMPLE_W'(ram_waddr_s);
`else
    assign ram_wdata_s = sample_data;
`endif

    spectrum_line_ram #(
        .DEPTH (N_PIXELS),
        .WIDTH (SAMPLE_W),
        .AW    (AW)
    ) u_line_ram (
        .clk   (clk_50m),
        .we    (ram_we_s),
        .waddr (ram_waddr_s),
        .wdata (ram_wdata_s),
        .raddr (ram_raddr_s),
        .rdata (ram_rdata_s)
    );

    // Next-state, next output byte, buffer addressing and checksum.
    // The output byte register is loaded with the byte of the state being
    // entered, so each state presents its byte from its first cycle. The RAM
    // read address runs one pixel ahead of the byte register: rdata already
    // holds pixel i while FCNT / DATA_HI(i-1) is in flight.
    always_comb begin
        state_s      = state_r;
        wr_addr_s    = wr_addr_r;
        rd_idx_s     = rd_idx_r;
        ram_raddr_s  = rd_idx_r;
        ram_we_s     = 1'b0;
        ram_waddr_s  = wr_addr_r;
        tx_data_s    = tx_data_r;
        tx_valid_s   = tx_valid_r;
        csum_s       = csum_r;
        fcnt_s       = fcnt_r;
        frame_done_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (sof_s) begin
                    ram_we_s    = 1'b1;
                    ram_waddr_s = AW'(0);
                    wr_addr_s   = AW'(1);
                    state_s     = ST_CAPTURE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CAPTURE: begin
                if (sample_valid) begin
                    ram_we_s = 1'b1;
                    if (wr_addr_r == LAST_ADDR) begin
                        state_s    = ST_HDR0;
                        tx_data_s  = HDR0;
                        tx_valid_s = 1'b1;
                        csum_s     = 8'h00;
                        rd_idx_s   = AW'(0);
                    end else begin
                        wr_addr_s = wr_addr_r + AW'(1);
                    end
                end else begin
                    state_s = ST_CAPTURE;
                end
            end
            ST_HDR0: begin
                if (xfer_s) begin
                    tx_data_s = HDR1;
                    state_s   = ST_HDR1;
                end else begin
                    state_s = ST_HDR0;
                end
            end
            ST_HDR1: begin
                if (xfer_s) begin
                    tx_data_s = fcnt_r;
                    state_s   = ST_FCNT;
                end else begin
                    state_s = ST_HDR1;
                end
            end
            ST_FCNT: begin
                if (xfer_s) begin
                    csum_s    = csum_r + tx_data_r;
                    tx_data_s = lo_byte(ram_rdata_s);
                    state_s   = ST_DATA_LO;
                end else begin
                    state_s = ST_FCNT;
                end
            end
            ST_DATA_LO: begin
                if (xfer_s) begin
                    csum_s      = csum_r + tx_data_r;
                    tx_data_s   = hi_byte(ram_rdata_s);
                    ram_raddr_s = next_idx_s;
                    state_s     = ST_DATA_HI;
                end else begin
                    state_s = ST_DATA_LO;
                end
            end
            ST_DATA_HI: begin
                ram_raddr_s = next_idx_s;
                if (xfer_s) begin
                    csum_s = csum_r + tx_data_r;
                    if (rd_idx_r == LAST_ADDR) begin
                        tx_data_s = csum_r + tx_data_r;
                        state_s   = ST_CSUM;
                    end else begin
                        rd_idx_s  = next_idx_s;
                        tx_data_s = lo_byte(ram_rdata_s);
                        state_s   = ST_DATA_LO;
                    end
                end else begin
                    state_s = ST_DATA_HI;
                end
            end
            ST_CSUM: begin
                if (xfer_s) begin
                    fcnt_s       = fcnt_r + 8'd1;
                    frame_done_s = 1'b1;
                    tx_valid_s   = 1'b0;
                    tx_data_s    = 8'h00;
                    state_s      = ST_IDLE;
                end else begin
                    state_s = ST_CSUM;
                end
            end
            default: begin
                state_s    = ST_IDLE;
                tx_valid_s = 1'b0;
                tx_data_s  = 8'h00;
            end
        endcase

        if (sof_s && sending_s && (drop_r != 8'hFF)) begin
            drop_s = drop_r + 8'd1;
        end else begin
            drop_s = drop_r;
        end

        busy_s = (state_s != ST_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk_50m) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            wr_addr_r  <= AW'(0);
            rd_idx_r   <= AW'(0);
            tx_data_r  <= 8'h00;
            tx_valid_r <= 1'b0;
            csum_r     <= 8'h00;
            fcnt_r     <= 8'h00;
            drop_r     <= 8'h00;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            wr_addr_r  <= wr_addr_s;
            rd_idx_r   <= rd_idx_s;
            tx_data_r  <= tx_data_s;
            tx_valid_r <= tx_valid_s;
            csum_r     <= csum_s;
            fcnt_r     <= fcnt_s;
            drop_r     <= drop_s;
            busy_r     <= busy_s;
        end
    end

    assign tx.tx_data       = tx_data_r;
    assign tx.tx_data_valid = tx_valid_r;
    assign busy             = busy_r;
    // Must coincide with the checksum transfer, so it follows ready directly.
    assign frame_done       = frame_done_s;
    assign dropped_frames   = drop_r;

endmodule
